// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback sources in, one register file write port out.
// The master side drives the write requests; the slave side is the arbiter.
interface regfile_wb_arbiter_if;
   logic        valid0;
   logic        ready0;
   logic [3:0]  reg0;
   logic [31:0] data0;
   logic        valid1;
   logic        ready1;
   logic [3:0]  reg1;
   logic [31:0] data1;
   logic        regwrite;
   logic [3:0]  write_reg;
   logic [31:0] write_data;
   logic [15:0] busy_mask;

   modport master (
      output valid0, reg0, data0, valid1, reg1, data1,
      input  ready0, ready1, regwrite, write_reg, write_data, busy_mask
   );

   modport slave (
      input  valid0, reg0, data0, valid1, reg1, data1,
      output ready0, ready1, regwrite, write_reg, write_data, busy_mask
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: pipeline writeback (port 0) vs buffered multi-cycle results
// (port 1). Define WB_ARB_STARVE_EN to enable the port 1 starvation guard.
module regfile_wb_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_params
      $error("regfile_wb_arbiter: FIFO_DEPTH or STARVE_LIMIT out of range");
   end

   logic [3:0]       r_fifo_reg  [FIFO_DEPTH];
   logic [31:0]      r_fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic        r_regwrite;
   logic [3:0]  r_write_reg;
   logic [31:0] r_write_data;

   logic             w_empty;
   logic             w_full;
   logic             w_match0;
   logic             w_starve;
   logic             w_ready0;
   logic             w_ready1;
   logic             w_grant0;
   logic             w_push;
   logic             w_pop;
   logic [PTR_W-1:0] w_offset;
   logic [15:0]      w_busy;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));

   // Scan live FIFO entries for the busy mask and for a port 0 WAW hazard.
   always_comb begin
      w_match0 = 1'b0;
      w_busy   = '0;
      w_offset = '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         w_offset = PTR_W'(i) - r_rd_ptr;
         if ({1'b0, w_offset} < r_count) begin
            w_busy[r_fifo_reg[i]] = 1'b1;
            if (r_fifo_reg[i] == bus.reg0) w_match0 = 1'b1;
         end
      end
      if (r_regwrite) w_busy[r_write_reg] = 1'b1;
      w_busy[0] = 1'b0;
   end

`ifdef WB_ARB_STARVE_EN
   logic [3:0] r_wait_cnt;

   assign w_starve = !w_empty && (r_wait_cnt >= 4'(STARVE_LIMIT));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wait_cnt <= '0;
      end else if (w_empty || w_pop) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != 4'hF) begin
         r_wait_cnt <= r_wait_cnt + 4'd1;
      end
   end
`else
   assign w_starve = 1'b0;
`endif

   assign w_ready0 = !((bus.reg0 != 4'd0) && w_match0) && !w_starve;
   assign w_ready1 = !w_full;
   assign w_grant0 = bus.valid0 && w_ready0;
   // Starvation already forces ready0 low, so the FIFO wins whenever port 0 does not.
   assign w_pop    = !w_empty && !w_grant0;
   assign w_push   = bus.valid1 && w_ready1;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fifo_reg[r_wr_ptr]  <= bus.reg1;
         r_fifo_data[r_wr_ptr] <= bus.data1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_regwrite   <= 1'b0;
         r_write_reg  <= '0;
         r_write_data <= '0;
      end else if (w_grant0) begin
         r_regwrite   <= (bus.reg0 != 4'd0);
         r_write_reg  <= bus.reg0;
         r_write_data <= bus.data0;
      end else if (w_pop) begin
         r_regwrite   <= (r_fifo_reg[r_rd_ptr] != 4'd0);
         r_write_reg  <= r_fifo_reg[r_rd_ptr];
         r_write_data <= r_fifo_data[r_rd_ptr];
      end else begin
         r_regwrite   <= 1'b0;
      end
   end

   assign bus.ready0     = w_ready0;
   assign bus.ready1     = w_ready1;
   assign bus.regwrite   = r_regwrite;
   assign bus.write_reg  = r_write_reg;
   assign bus.write_data = r_write_data;
   assign bus.busy_mask  = w_busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, multi-cycle corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned LIMIT = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter #(
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   typedef struct {
      logic        v0;
      logic [3:0]  r0;
      logic [31:0] d0;
      logic        v1;
      logic [3:0]  r1;
      logic [31:0] d1;
      logic        rdy0;
      logic        rdy1;
      logic        rw;
      logic [3:0]  wr;
      logic [31:0] wd;
      logic [15:0] busy;
   } vec_t;

   typedef struct {
      logic [3:0]  r;
      logic [31:0] d;
   } ent_t;

   vec_t vecs [10];
   ent_t m_q [$];
   ent_t got [$];
   ent_t e;

   int n_tests = 0;
   int n_fail  = 0;
   int found;
   int exp_found;
   int m_wait;
   logic m_rw;
   logic [3:0]  m_wr;
   logic [31:0] m_wd;
   logic [15:0] m_busy;
   logic acc1, blk, stv, e_rdy0, e_rdy1, was_empty, popped;
   logic rv0, rv1;
   logic [3:0]  rr0, rr1;
   logic [31:0] rd0, rd1;
   logic [3:0]  exp_regs [3];
   logic [31:0] exp_data [3];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests = n_tests + 1;
      if (act !== expv) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic drive(input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                        input logic v1, input logic [3:0] r1, input logic [31:0] d1);
      bus.valid0 = v0;
      bus.reg0   = r0;
      bus.data0  = d0;
      bus.valid1 = v1;
      bus.reg1   = r1;
      bus.data1  = d1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_outputs(input string tag, input logic rw, input logic [3:0] wr,
                                input logic [31:0] wd, input logic [15:0] busy);
      check({tag, ".regwrite"}, 32'(bus.regwrite), 32'(rw));
      check({tag, ".write_reg"}, 32'(bus.write_reg), 32'(wr));
      check({tag, ".write_data"}, bus.write_data, wd);
      check({tag, ".busy_mask"}, 32'(bus.busy_mask), 32'(busy));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // rows start from a freshly reset arbiter; idle rows drive reg0 = 0
      vecs[0] = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,
                  1'b1, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 16'h0020};
      vecs[1] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 32'h12,
                  1'b1, 1'b1, 1'b0, 4'd5, 32'hDEADBEEF, 16'h0008};
      vecs[2] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
                  1'b1, 1'b1, 1'b1, 4'd3, 32'h12, 16'h0008};
      vecs[3] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
                  1'b1, 1'b1, 1'b0, 4'd3, 32'h12, 16'h0000};
      vecs[4] = '{1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'hA9,
                  1'b1, 1'b1, 1'b0, 4'd3, 32'h12, 16'h0200};
      vecs[5] = '{1'b1, 4'd9, 32'hB9, 1'b0, 4'd0, 32'h0,
                  1'b0, 1'b1, 1'b1, 4'd9, 32'hA9, 16'h0200};
      vecs[6] = '{1'b1, 4'd9, 32'hB9, 1'b0, 4'd0, 32'h0,
                  1'b1, 1'b1, 1'b1, 4'd9, 32'hB9, 16'h0200};
      vecs[7] = '{1'b1, 4'd0, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h0,
                  1'b1, 1'b1, 1'b0, 4'd0, 32'hFFFFFFFF, 16'h0000};
      vecs[8] = '{1'b1, 4'd6, 32'h66, 1'b1, 4'd7, 32'h77,
                  1'b1, 1'b1, 1'b1, 4'd6, 32'h66, 16'h00C0};
      vecs[9] = '{1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,
                  1'b1, 1'b1, 1'b1, 4'd7, 32'h77, 16'h0080};

      rst = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      @(posedge clk);
      #1;
      check_outputs("reset", 1'b0, 4'd0, 32'd0, 16'd0);
      check("reset.ready0", 32'(bus.ready0), 32'd1);
      check("reset.ready1", 32'(bus.ready1), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // directed vector table
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].v0, vecs[i].r0, vecs[i].d0, vecs[i].v1, vecs[i].r1, vecs[i].d1);
         #1;
         check($sformatf("vec%0d.ready0", i), 32'(bus.ready0), 32'(vecs[i].rdy0));
         check($sformatf("vec%0d.ready1", i), 32'(bus.ready1), 32'(vecs[i].rdy1));
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].busy);
         @(negedge clk);
      end

      // port 0 saturating while a reg 7 write waits in the FIFO
      do_reset();
      drive(1'b1, 4'd1, 32'h11, 1'b1, 4'd7, 32'h70);
      @(negedge clk);
      drive(1'b1, 4'd1, 32'h11, 1'b0, 4'd0, 32'h0);
      found = -1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         if (found < 0 && bus.regwrite && bus.write_reg == 4'd7) found = c;
      end
`ifdef WB_ARB_STARVE_EN
      exp_found = LIMIT + 1;
`else
      exp_found = -1;
`endif
      check("starve.cycle_of_reg7", 32'(found), 32'(exp_found));
      @(negedge clk);
      bus.valid0 = 1'b0;
      @(posedge clk);
      #1;
      check("starve.drain_after_v0_drop", 32'(bus.regwrite), 32'(exp_found < 0));
      check("starve.drain_reg", 32'(bus.write_reg), (exp_found < 0) ? 32'd7 : 32'd1);

      // FIFO fill: third push refused and retained upstream
      do_reset();
      exp_regs = '{4'd10, 4'd11, 4'd12};
      exp_data = '{32'hA0, 32'hB0, 32'hC0};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'd1, 32'h1, 1'b1, exp_regs[i], exp_data[i]);
         #1;
         check($sformatf("fill.ready1_push%0d", i), 32'(bus.ready1), (i < 2) ? 32'd1 : 32'd0);
         if (i < 2) begin
            @(posedge clk);
            @(negedge clk);
         end
      end
      @(posedge clk);
      @(negedge clk);
      bus.valid0 = 1'b0;
      got.delete();
      for (int c = 0; c < 8; c++) begin
         #1;
         acc1 = bus.valid1 && bus.ready1;
         @(posedge clk);
         #1;
         if (bus.regwrite) got.push_back('{bus.write_reg, bus.write_data});
         if (acc1) bus.valid1 = 1'b0;
         @(negedge clk);
      end
      check("fill.write_count", 32'(got.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         e = (i < got.size()) ? got[i] : '{4'hx, 32'hx};
         check($sformatf("fill.order%0d_reg", i), 32'(e.r), 32'(exp_regs[i]));
         check($sformatf("fill.order%0d_data", i), e.d, exp_data[i]);
      end

      // asynchronous reset in the middle of a burst
      do_reset();
      drive(1'b1, 4'd2, 32'h22, 1'b1, 4'd4, 32'h44);
      @(negedge clk);
      drive(1'b1, 4'd3, 32'h33, 1'b1, 4'd5, 32'h55);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_outputs("midrst", 1'b0, 4'd0, 32'd0, 16'd0);
      check("midrst.ready0", 32'(bus.ready0), 32'd1);
      check("midrst.ready1", 32'(bus.ready1), 32'd1);
      drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("midrst.no_write%0d", c), 32'(bus.regwrite), 32'd0);
      end

      // randomized traffic against the queue model
      do_reset();
      m_q.delete();
      m_wait = 0;
      m_rw   = 1'b0;
      m_wr   = 4'd0;
      m_wd   = 32'd0;
      for (int n = 0; n < 400; n++) begin
         rv0 = ($urandom_range(0, 9) < 8);
         rr0 = 4'($urandom_range(0, 5));
         rd0 = $urandom;
         rv1 = ($urandom_range(0, 2) == 0);
         rr1 = 4'($urandom_range(0, 5));
         rd1 = $urandom;
         drive(rv0, rr0, rd0, rv1, rr1, rd1);
         blk = 1'b0;
         foreach (m_q[k]) if (rr0 != 4'd0 && m_q[k].r == rr0) blk = 1'b1;
`ifdef WB_ARB_STARVE_EN
         stv = (m_q.size() > 0) && (m_wait >= LIMIT);
`else
         stv = 1'b0;
`endif
         e_rdy0 = !blk && !stv;
         e_rdy1 = (m_q.size() < DEPTH);
         #1;
         check("rand.ready0", 32'(bus.ready0), 32'(e_rdy0));
         check("rand.ready1", 32'(bus.ready1), 32'(e_rdy1));
         @(posedge clk);
         was_empty = (m_q.size() == 0);
         popped    = 1'b0;
         if (rv0 && e_rdy0) begin
            m_rw = (rr0 != 4'd0);
            m_wr = rr0;
            m_wd = rd0;
         end else if (!was_empty) begin
            e      = m_q.pop_front();
            m_rw   = (e.r != 4'd0);
            m_wr   = e.r;
            m_wd   = e.d;
            popped = 1'b1;
         end else begin
            m_rw = 1'b0;
         end
         if (rv1 && e_rdy1) m_q.push_back('{rr1, rd1});
         m_wait = (was_empty || popped) ? 0 : ((m_wait < 15) ? m_wait + 1 : 15);
         m_busy = '0;
         foreach (m_q[k]) m_busy[m_q[k].r] = 1'b1;
         if (m_rw) m_busy[m_wr] = 1'b1;
         m_busy[0] = 1'b0;
         #1;
         check_outputs("rand", m_rw, m_wr, m_wd, m_busy);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
